// File: rtl/emat_pkg.sv
// Shared types and default widths for the EMAT acquisition sequencer.
package emat_pkg;

    localparam int SHOT_W_DEF   = 4;
    localparam int PRF_W_DEF    = 24;
    localparam int DLY_W_DEF    = 16;
    localparam int WDOG_CYC_DEF = 1000000;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FIRE      = 4'd1,
        BLANK     = 4'd2,
        CAPT      = 4'd3,
        WAIT_FULL = 4'd4,
        WAIT_PRF  = 4'd5,
        WAIT_RDY  = 4'd6,
        DRAIN     = 4'd7,
        DONE      = 4'd8
    } state_t;

endpackage

// File: rtl/emat_down_counter.sv
// Loadable down counter that stops at zero and flags it.
module emat_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/emat_acq_sequencer.sv
// Sequences one EMAT measurement: fire, blank, capture N shots, hand off readout.
// Optional watchdog on the waiting states is built when ACQ_WDOG_EN is defined.
module emat_acq_sequencer
    import emat_pkg::*;
#(
    parameter int SHOT_W   = SHOT_W_DEF,
    parameter int PRF_W    = PRF_W_DEF,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int WDOG_CYC = WDOG_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [SHOT_W-1:0] shot_count,
    input  logic [PRF_W-1:0]  prf_period,
    input  logic [DLY_W-1:0]  blank_dly,
    input  logic              avg_full,
    input  logic              avg_ready,
    input  logic              arm_rd_ready,
    output logic              tx_fire,
    output logic              cap_start,
    output logic              dout_enable,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [SHOT_W-1:0] shot_idx
);

    state_t state, state_nxt;

    logic [SHOT_W-1:0] shots_q;
    logic [PRF_W-1:0]  prf_q;
    logic [DLY_W-1:0]  blank_q;
    logic [PRF_W-1:0]  period;
    logic [DLY_W-1:0]  blank_load;
    logic [SHOT_W:0]   shot_inc;
    logic              prf_hit;
    logic              blank_zero;
    logic              accept;
    logic              timeout;

    assign accept   = (state == IDLE) && start && !abort;
    assign shot_inc = {1'b0, shot_idx} + {{SHOT_W{1'b0}}, 1'b1};
    // Late-running captures simply fire again on the next cycle.
    assign prf_hit  = ({1'b0, period} + {{PRF_W{1'b0}}, 1'b1}) >= {1'b0, prf_q};
    // BLANK lasts blank_dly cycles, but never less than one.
    assign blank_load = (blank_q == '0) ? '0 : blank_q - DLY_W'(1);

    emat_down_counter #(.W(DLY_W)) u_blank (
        .clk      (clk),
        .reset    (reset),
        .load     (state == FIRE),
        .load_val (blank_load),
        .en       (state == BLANK),
        .zero     (blank_zero)
    );

`ifdef ACQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic wd_in;
    logic wd_enter;
    logic wd_zero;

    assign wd_in    = (state == WAIT_FULL) || (state == WAIT_RDY)
                   || (state == DRAIN);
    assign wd_enter = (state_nxt != state)
                   && ((state_nxt == WAIT_FULL) || (state_nxt == WAIT_RDY)
                   ||  (state_nxt == DRAIN));

    emat_down_counter #(.W(WD_W)) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_enter),
        .load_val (WD_W'(WDOG_CYC - 1)),
        .en       (wd_in),
        .zero     (wd_zero)
    );

    assign timeout = wd_in && wd_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if (accept) begin
            err_timeout <= 1'b0;
        end else if (timeout) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start) state_nxt = FIRE;
            FIRE:      state_nxt = BLANK;
            BLANK:     if (blank_zero) state_nxt = CAPT;
            CAPT:      state_nxt = WAIT_FULL;
            WAIT_FULL: begin
                if (avg_full) begin
                    state_nxt = (shot_inc >= {1'b0, shots_q}) ? WAIT_RDY
                                                              : WAIT_PRF;
                end
            end
            WAIT_PRF:  if (prf_hit) state_nxt = FIRE;
            WAIT_RDY:  if (avg_ready && arm_rd_ready) state_nxt = DRAIN;
            DRAIN:     if (!avg_ready) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        if (timeout) state_nxt = IDLE;
        if (abort)   state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_fire     <= 1'b0;
            cap_start   <= 1'b0;
            dout_enable <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_fire     <= (state_nxt == FIRE);
            cap_start   <= (state_nxt == CAPT);
            dout_enable <= (state == WAIT_RDY) && (state_nxt == DRAIN);
            done        <= (state_nxt == DONE);
            busy        <= (state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shots_q  <= '0;
            prf_q    <= '0;
            blank_q  <= '0;
            shot_idx <= '0;
        end else if (accept) begin
            shots_q  <= (shot_count == '0) ? SHOT_W'(1) : shot_count;
            prf_q    <= prf_period;
            blank_q  <= blank_dly;
            shot_idx <= '0;
        end else if (state == WAIT_FULL
                  && (state_nxt == WAIT_RDY || state_nxt == WAIT_PRF)) begin
            shot_idx <= shot_inc[SHOT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= '0;
        end else if (state_nxt == FIRE) begin
            period <= '0;
        end else if (period != '1) begin
            period <= period + PRF_W'(1);
        end
    end

endmodule

// File: tb/tb_emat_acq_sequencer.sv
// Directed bench: expected strobe events are queued at start and matched as the DUT emits them.
module tb_emat_acq_sequencer;

    localparam int SHOT_W = 4;
    localparam int PRF_W  = 24;
    localparam int DLY_W  = 16;
`ifdef ACQ_WDOG_EN
    localparam int WDOG = 500;
`else
    localparam int WDOG = 1000000;
`endif

    localparam int K_FIRE = 0;
    localparam int K_CAP  = 1;
    localparam int K_DOUT = 2;
    localparam int K_DONE = 3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [SHOT_W-1:0] shot_count;
    logic [PRF_W-1:0]  prf_period;
    logic [DLY_W-1:0]  blank_dly;
    logic              avg_full;
    logic              avg_ready;
    logic              arm_rd_ready;
    logic              tx_fire;
    logic              cap_start;
    logic              dout_enable;
    logic              busy;
    logic              done;
    logic              err_timeout;
    logic [SHOT_W-1:0] shot_idx;

    emat_acq_sequencer #(
        .SHOT_W   (SHOT_W),
        .PRF_W    (PRF_W),
        .DLY_W    (DLY_W),
        .WDOG_CYC (WDOG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .shot_count   (shot_count),
        .prf_period   (prf_period),
        .blank_dly    (blank_dly),
        .avg_full     (avg_full),
        .avg_ready    (avg_ready),
        .arm_rd_ready (arm_rd_ready),
        .tx_fire      (tx_fire),
        .cap_start    (cap_start),
        .dout_enable  (dout_enable),
        .busy         (busy),
        .done         (done),
        .err_timeout  (err_timeout),
        .shot_idx     (shot_idx)
    );

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];
    int  passed = 0;
    int  total  = 0;
    int  cyc    = 0;
    int  full_dly = 0;
    int  full_cnt = 0;
    int  fulls    = 0;
    int  need     = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string tag, input longint obs,
                                input longint exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    endfunction

    // Strobe monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        int n;
        int kind;
        ev_t ev;
        n = int'(tx_fire) + int'(cap_start) + int'(dout_enable) + int'(done);
        kind = tx_fire ? K_FIRE : cap_start ? K_CAP
             : dout_enable ? K_DOUT : K_DONE;
        if (n > 1) chk("strobe_exclusive", n, 1);
        if (n == 1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", kind, -1);
            end else begin
                ev = exp_q.pop_front();
                chk("strobe_kind", kind, ev.kind);
                chk("strobe_cycle", cyc, ev.at);
            end
        end
    end

    // Averager model: full some cycles after capture, ready after the last shot.
    always @(negedge clk) begin
        if (dout_enable) begin
            avg_ready = 1'b0;
            avg_full  = 1'b0;
        end
        if (cap_start) begin
            avg_full = 1'b0;
            full_cnt = full_dly;
        end else if (full_cnt > 0) begin
            full_cnt = full_cnt - 1;
            if (full_cnt == 0) begin
                avg_full = 1'b1;
                fulls = fulls + 1;
                if (fulls >= need) avg_ready = 1'b1;
            end
        end
    end

    task automatic push(input int kind, input int at);
        ev_t ev;
        ev.kind = kind;
        ev.at   = at;
        exp_q.push_back(ev);
    endtask

    task automatic plan(input int shots, input int p, input int b,
                        input int f, input bit arm, input int s);
        int eff;
        int fire;
        int cap;
        int w;
        eff  = (shots == 0) ? 1 : shots;
        fire = s + 1;
        w    = 0;
        for (int i = 0; i < eff; i++) begin
            push(K_FIRE, fire);
            cap = fire + ((b < 1) ? 1 : b) + 1;
            push(K_CAP, cap);
            w = cap + f + 1;
            if (i < eff - 1) fire = (fire + p > w + 1) ? fire + p : w + 1;
        end
        if (arm) begin
            push(K_DOUT, w + 1);
            push(K_DONE, w + 2);
        end
    endtask

    task automatic kick(input int shots, input int p, input int b,
                        input int f, input bit arm, input bit do_plan,
                        output int s);
        shot_count   = SHOT_W'(shots);
        prf_period   = PRF_W'(p);
        blank_dly    = DLY_W'(b);
        arm_rd_ready = arm;
        full_dly     = f;
        full_cnt     = 0;
        fulls        = 0;
        need         = (shots == 0) ? 1 : shots;
        avg_full     = 1'b0;
        avg_ready    = 1'b0;
        @(negedge clk);
        s = cyc;
        if (do_plan) plan(shots, p, b, f, arm, s);
        else push(K_FIRE, s + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s;
        int a;
        reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        shot_count   = '0;
        prf_period   = '0;
        blank_dly    = '0;
        avg_full     = 1'b0;
        avg_ready    = 1'b0;
        arm_rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {tx_fire, cap_start, dout_enable, busy, done,
                            err_timeout}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_shot_idx", shot_idx, 0);

        // 1: two shots, long period
        kick(2, 100, 10, 30, 1, 1, s);
        chk("t1_busy", busy, 1);
        wait_idle("t1");
        chk("t1_shot_idx", shot_idx, 2);
        chk("t1_err", err_timeout, 0);

        // 2: zero shots means one
        kick(0, 60, 3, 8, 1, 1, s);
        wait_idle("t2");
        chk("t2_shot_idx", shot_idx, 1);

        // 3: capture outruns the period; a stray start mid-run is ignored
        kick(2, 20, 10, 40, 1, 1, s);
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t3");
        chk("t3_shot_idx", shot_idx, 2);
        chk("t3_err", err_timeout, 0);

        // 4: ARM side not ready holds off readout
        kick(1, 50, 2, 5, 0, 1, s);
        repeat (200) @(negedge clk);
        chk("t4_busy_hold", busy, 1);
        chk("t4_shot_idx", shot_idx, 1);
        a = cyc;
        push(K_DOUT, a + 1);
        push(K_DONE, a + 2);
        arm_rd_ready = 1'b1;
        wait_idle("t4");

        // 5: abort during blanking, then a normal run
        kick(1, 100, 10, 20, 1, 0, s);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_shot_idx", shot_idx, 0);
        repeat (30) @(negedge clk);
        chk("t5_no_more_strobes", exp_q.size(), 0);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_start_abort_idle", busy, 0);
        kick(1, 40, 0, 6, 1, 1, s);
        wait_idle("t5b");
        chk("t5b_shot_idx", shot_idx, 1);

`ifdef ACQ_WDOG_EN
        // 6: averager never fills, watchdog expires
        kick(1, 100, 3, 0, 1, 0, s);
        push(K_CAP, s + 5);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (err_timeout) break;
        end
        chk("t6_err_set", err_timeout, 1);
        chk("t6_err_cycle", cyc, s + 506);
        chk("t6_idle", busy, 0);
        chk("t6_queue_empty", exp_q.size(), 0);
        kick(1, 40, 2, 5, 1, 1, s);
        chk("t6_err_cleared", err_timeout, 0);
        wait_idle("t6b");
`endif

        // 7: reset mid-measurement
        kick(3, 100, 2, 5, 1, 0, s);
        push(K_CAP, s + 4);
        repeat (30) @(negedge clk);
        chk("t7_mid_shot_idx", shot_idx, 1);
        reset = 1'b1;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_shot_idx", shot_idx, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_queue_empty", exp_q.size(), 0);
        chk("t7_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/emat_acq_sequencer.md
Name: emat_acq_sequencer

Overview:
Sequences one EMAT thickness measurement around the accumulate-average block.
- Fires the excitation driver at a programmed pulse-repetition period and waits a blanking delay.
- Pulses the averager's capture start and counts shots until the programmed number is captured.
- When ARM readout is ready, grants the averager's readout (dout_enable).
- Sits between the ARM register interface, the excitation driver and the averager.

Parameters:
SHOT_W, 4, width of shot_count and shot_idx
PRF_W, 24, width of prf_period and the period counter
DLY_W, 16, width of blank_dly and the blanking counter
WDOG_CYC, 1000000, watchdog limit in clk cycles (used only with ACQ_WDOG_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a measurement; ignored unless IDLE
abort  in  1  level; forces return to IDLE from any state
shot_count  in  SHOT_W  shots per measurement; 0 treated as 1; sampled at start
prf_period  in  PRF_W  clk cycles from fire to next fire; sampled at start
blank_dly  in  DLY_W  clk cycles from tx_fire to cap_start; sampled at start
avg_full  in  1  averager record-complete flag (its FIFO full)
avg_ready  in  1  averager dout_ready
arm_rd_ready  in  1  ARM side can accept a readout (ARM FIFO not full)
tx_fire  out  1  one-cycle excitation pulse
cap_start  out  1  one-cycle pulse to averager data_in_valid
dout_enable  out  1  one-cycle readout grant to averager
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a measurement completes
err_timeout  out  1  sticky watchdog error; cleared by the next accepted start
shot_idx  out  SHOT_W  shots completed in the current measurement

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; all counters 0.
- All outputs are registered.

States and transitions:
- IDLE
  - start=1 latches the config, clears shot_idx and err_timeout, then goes to FIRE.
- FIRE
  - Asserts tx_fire for one cycle.
  - Clears the period counter, which then increments every cycle until the next FIRE.
  - Goes to BLANK.
- BLANK
  - Counts blank_dly cycles, then goes to CAPT.
  - blank_dly=0 goes to CAPT on the next cycle.
- CAPT
  - Asserts cap_start for one cycle, then goes to WAIT_FULL.
- WAIT_FULL
  - Waits for avg_full=1 (a rising edge is not required).
  - Then increments shot_idx.
  - If shot_idx+1 ≥ effective shot_count, goes to WAIT_RDY; otherwise goes to WAIT_PRF.
- WAIT_PRF
  - Goes to FIRE when the period counter reaches prf_period-1.
  - If that point has already passed (capture longer than the period), goes to FIRE on the next cycle. This is not an error.
- WAIT_RDY
  - Waits for avg_ready=1 and arm_rd_ready=1 in the same cycle.
  - Then asserts dout_enable for one cycle and goes to DRAIN.
- DRAIN
  - Waits for avg_ready=0 (averager has begun its read), then goes to DONE.
- DONE
  - Asserts done for one cycle, then goes to IDLE.

Boundary rules:
- abort has priority over every transition. Next state is IDLE with strobes 0 and shot_idx held. done is not pulsed.
- start while busy is ignored; no queuing.
- start and abort in the same cycle in IDLE: abort wins; stay IDLE.
- The period counter saturates at all-ones; it never wraps.
- reset mid-operation: immediate return to IDLE with reset values. The averager is reset independently.
- tx_fire, cap_start, dout_enable and done are mutually exclusive and never high for two consecutive cycles.

Optional Feature:
ACQ_WDOG_EN
- Defined:
  - A watchdog counter runs in WAIT_FULL, WAIT_RDY and DRAIN, and clears on each state entry.
  - Reaching WDOG_CYC sets err_timeout and goes to IDLE without done.
- Not defined:
  - No watchdog logic is built; those states wait indefinitely.
  - err_timeout is tied to 0.

Decomposition:
- Shared package emat_pkg holds:
  - the state enum encoding: IDLE=0, FIRE=1, BLANK=2, CAPT=3, WAIT_FULL=4, WAIT_PRF=5, WAIT_RDY=6, DRAIN=7, DONE=8 (4 bits);
  - the default widths.
- One sub-module, emat_down_counter: loadable down counter with a zero flag.
  - Instantiated for the blanking count.
  - Also instantiated for the watchdog when ACQ_WDOG_EN is defined.

Test Plan:
1. Reset released, start with shot_count=2, prf_period=100, blank_dly=10; avg_full high 30 cycles after each cap_start; avg_ready set after the second full; arm_rd_ready=1.
   -> tx_fire at cycles 1 and 101 after start; cap_start 11 cycles after each fire; one dout_enable; done once; shot_idx=2.
2. shot_count=0 -> exactly one tx_fire and one cap_start, then readout.
3. prf_period=20 with capture taking 50 cycles -> second tx_fire one cycle after WAIT_PRF entry; no error.
4. arm_rd_ready held 0 for 200 cycles with avg_ready=1 -> no dout_enable, busy=1; dout_enable the cycle after arm_rd_ready rises.
5. abort during BLANK of shot 1 -> IDLE next cycle, no cap_start, no done, busy=0; a following start runs normally.
6. With ACQ_WDOG_EN and WDOG_CYC=500, avg_full never asserted -> err_timeout=1 at 500 cycles in WAIT_FULL, IDLE, no done; the next start clears err_timeout.
